// File: rtl/icache_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : icache_fetch
//  Purpose  : Direct-mapped, blocking, read-only instruction cache for the
//             fetch stage. Two-stage hit path (lookup, compare) returning up
//             to FETCH_WIDTH words without crossing a line. Misses refill a
//             full line through a burst read port.
//  Revision : 1.0 - initial release
// ============================================================================
module icache_fetch #(
    parameter int FETCH_WIDTH = 4,
    parameter int LINE_WORDS  = 8,
    parameter int SETS        = 64,
    parameter int ADDR_W      = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [ADDR_W-1:0]                req_pc,
    input  logic                             flush,
    output logic                             resp_valid,
    output logic [ADDR_W-1:0]                resp_pc,
    output logic [FETCH_WIDTH*32-1:0]        resp_inst,
    output logic [$clog2(FETCH_WIDTH+1)-1:0] resp_count,
    output logic                             resp_adel,
    output logic                             mem_arvalid,
    input  logic                             mem_arready,
    output logic [ADDR_W-1:0]                mem_araddr,
    input  logic                             mem_rvalid,
    input  logic [31:0]                      mem_rdata,
    input  logic                             mem_rlast
);

    localparam int c_OFF_W  = $clog2(LINE_WORDS);
    localparam int c_IDX_W  = $clog2(SETS);
    localparam int c_LO     = c_OFF_W + 2;
    localparam int c_TAG_W  = ADDR_W - c_IDX_W - c_LO;
    localparam int c_CNT_W  = $clog2(FETCH_WIDTH + 1);
    localparam int c_REM_W  = c_OFF_W + 1;
    localparam int c_LINE_W = LINE_WORDS * 32;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_AREQ   = 3'd1;
    localparam logic [2:0] c_ST_REFILL = 3'd2;
    localparam logic [2:0] c_ST_RESP   = 3'd3;
    localparam logic [2:0] c_ST_DRAIN  = 3'd4;

    logic [2:0]          r_state;
    logic [SETS-1:0]     r_valid;
    logic [c_TAG_W-1:0]  r_tag_mem  [SETS];
    logic [c_LINE_W-1:0] r_data_mem [SETS];

    logic                r_s2_valid;
    logic [ADDR_W-1:0]   r_s2_pc;
    logic                r_s2_vbit;
    logic [c_TAG_W-1:0]  r_s2_tag;
    logic [c_LINE_W-1:0] r_s2_line;

    logic [ADDR_W-1:0]   r_miss_pc;
    logic                r_arvalid;
    logic [ADDR_W-1:0]   r_araddr;
    logic [c_OFF_W-1:0]  r_beat;
    logic [c_LINE_W-1:0] r_buf;
    logic                r_kill;

    logic                w_accept;
    logic [c_IDX_W-1:0]  w_req_idx;
    logic                w_misal;
    logic                w_hit;
    logic                w_miss;
    logic                w_s2_live;
    logic                w_fill_done;
    logic [c_IDX_W-1:0]  w_miss_idx;
    logic [c_TAG_W-1:0]  w_miss_tag;
    logic [c_LINE_W-1:0] w_buf_next;
    logic                w_resp_hit;
    logic                w_resp_adel;
    logic                w_resp_fill;
    logic [ADDR_W-1:0]   w_sel_pc;
    logic [c_LINE_W-1:0] w_sel_line;
    logic [c_OFF_W-1:0]  w_off;
    logic [c_REM_W-1:0]  w_rem;
    logic [c_CNT_W-1:0]  w_count;
    logic [c_CNT_W-1:0]  w_count_out;
    logic [c_OFF_W-1:0]  w_word;
    logic [FETCH_WIDTH*32-1:0] w_inst;

    assign w_accept   = req_valid && req_ready;
    assign w_req_idx  = req_pc[c_LO +: c_IDX_W];

    // Stage-2 compare; a misaligned PC never counts as a hit or a miss.
    assign w_misal    = |r_s2_pc[1:0];
    assign w_hit      = r_s2_vbit && (r_s2_tag == r_s2_pc[ADDR_W-1 -: c_TAG_W]);
    assign w_miss     = r_s2_valid && !w_misal && !w_hit;
    assign w_s2_live  = r_s2_valid && !flush;

    // A stalled miss or a flush holds off new requests.
    assign req_ready  = (r_state == c_ST_IDLE) && !w_miss && !flush;

    assign w_miss_idx  = r_miss_pc[c_LO +: c_IDX_W];
    assign w_miss_tag  = r_miss_pc[ADDR_W-1 -: c_TAG_W];
    assign w_fill_done = (r_state == c_ST_REFILL) && mem_rvalid && mem_rlast && !flush;

    // Merge the current beat into the line buffer so the last beat can be
    // written to the array on the same edge it arrives.
    always_comb begin
        w_buf_next = r_buf;
        w_buf_next[{r_beat, 5'b0} +: 32] = mem_rdata;
    end

    // Valid bits and the stage-1 request register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            r_s2_valid <= 1'b0;
            r_s2_pc    <= '0;
            r_s2_vbit  <= 1'b0;
        end else begin
            r_s2_valid <= w_accept;
            if (w_accept) begin
                r_s2_pc   <= req_pc;
                r_s2_vbit <= r_valid[w_req_idx];
            end
            if (flush) begin
                r_valid <= '0;
            end else if (w_fill_done) begin
                r_valid[w_miss_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays: synchronous read on accept, write on refill end.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s2_tag  <= r_tag_mem[w_req_idx];
            r_s2_line <= r_data_mem[w_req_idx];
        end
        if (w_fill_done) begin
            r_tag_mem[w_miss_idx]  <= w_miss_tag;
            r_data_mem[w_miss_idx] <= w_buf_next;
        end
    end

    // Miss handling: address request, burst refill, response, or drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_miss_pc <= '0;
            r_arvalid <= 1'b0;
            r_araddr  <= '0;
            r_beat    <= '0;
            r_buf     <= '0;
            r_kill    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_miss && !flush) begin
                        r_miss_pc <= r_s2_pc;
                        r_araddr  <= {r_s2_pc[ADDR_W-1:c_LO], {c_LO{1'b0}}};
                        r_arvalid <= 1'b1;
                        r_kill    <= 1'b0;
                        r_state   <= c_ST_AREQ;
                    end
                end
                c_ST_AREQ: begin
                    // The request cannot be withdrawn, so a flush here is
                    // remembered and the burst is drained afterwards.
                    if (flush) begin
                        r_kill <= 1'b1;
                    end
                    if (mem_arready) begin
                        r_arvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= (r_kill || flush) ? c_ST_DRAIN : c_ST_REFILL;
                    end
                end
                c_ST_REFILL: begin
                    if (flush) begin
                        r_state <= (mem_rvalid && mem_rlast) ? c_ST_IDLE : c_ST_DRAIN;
                    end else if (mem_rvalid) begin
                        r_buf  <= w_buf_next;
                        r_beat <= r_beat + c_OFF_W'(1);
                        if (mem_rlast) begin
                            r_state <= c_ST_RESP;
                        end
                    end
                end
                c_ST_RESP: begin
                    r_state <= c_ST_IDLE;
                end
                c_ST_DRAIN: begin
                    if (mem_rvalid && mem_rlast) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign mem_arvalid = r_arvalid;
    assign mem_araddr  = r_araddr;

    // Response source: either a stage-2 hit/misalignment or the refilled line.
    assign w_resp_hit  = w_s2_live && !w_misal && w_hit;
    assign w_resp_adel = w_s2_live && w_misal;
    assign w_resp_fill = (r_state == c_ST_RESP) && !flush;
    assign w_sel_pc    = w_resp_fill ? r_miss_pc : r_s2_pc;
    assign w_sel_line  = w_resp_fill ? r_buf : r_s2_line;

    // Fetch group stops at the end of the line.
    assign w_off       = w_sel_pc[2 +: c_OFF_W];
    assign w_rem       = c_REM_W'(LINE_WORDS) - {1'b0, w_off};
    assign w_count     = (w_rem > c_REM_W'(FETCH_WIDTH)) ? c_CNT_W'(FETCH_WIDTH)
                                                          : w_rem[c_CNT_W-1:0];
    assign w_count_out = (w_resp_hit || w_resp_fill) ? w_count : '0;

    assign resp_valid  = w_resp_hit || w_resp_fill || w_resp_adel;
    assign resp_adel   = w_resp_adel;
    assign resp_pc     = resp_valid ? w_sel_pc : '0;
    assign resp_count  = w_count_out;

    // Slot extraction; unused slots read as zero.
    always_comb begin
        w_word = '0;
        w_inst = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (c_CNT_W'(i) < w_count_out) begin
                w_word = w_off + c_OFF_W'(i);
                w_inst[i*32 +: 32] = w_sel_line[{w_word, 5'b0} +: 32];
            end
        end
    end

    assign resp_inst = w_inst;

endmodule
`default_nettype wire
